// File: rtl/incr_share_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared incrementer.
// Holds the FSM state encoding and the operand width.
package incr_share_arbiter_pkg;

  localparam int OPW = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/incr_share_arbiter_rr_pick.sv
// Combinational round-robin picker: scans upward from ptr with wrap-around.
// The first set request bit wins. any is low when no request is pending.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/increment4bit.sv
// 4-bit incrementer built as a half-adder ripple chain.
// ca_out is set only when a is 4'hF, so s wraps to 4'h0.
module increment4bit (
  input  logic [3:0] a,
  output logic [3:0] s,
  output logic       ca_out
);

  logic [4:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ c[i];
    assign c[i+1] = a[i] & c[i];
  end

  assign ca_out = c[4];

endmodule

// File: rtl/incr_share_arbiter.sv
// Shares one increment4bit between NUM_REQ requesters via round-robin arbitration.
// Each accepted request takes two cycles: grant (EXEC) then a registered done pulse.
module incr_share_arbiter
  import incr_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [OPW*NUM_REQ-1:0] operand,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic [OPW-1:0]         result,
  output logic                   carry,
  output logic                   done,
  output logic [ID_W-1:0]        done_id
);

  state_e               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr;
  logic [OPW-1:0]       op_q;
  logic [ID_W-1:0]      id_q;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 accept;

  logic [OPW-1:0]       op_arr [NUM_REQ];
  logic [OPW-1:0]       inc_sum;
  logic                 inc_co;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_op
    assign op_arr[k] = operand[k*OPW +: OPW];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  increment4bit u_inc (
    .a      (op_q),
    .s      (inc_sum),
    .ca_out (inc_co)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (en && pick_any) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ST_EXEC);
    accept = (state == ST_IDLE) && en && pick_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      gnt     <= '0;
      result  <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (accept) begin
        gnt    <= pick_onehot;
        rr_ptr <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
      if (busy) begin
        result  <= inc_sum;
        carry   <= inc_co;
        done    <= 1'b1;
        done_id <= id_q;
      end
    end
  end

  // NOTE: op_q/id_q are always written on accept before EXEC reads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op_arr[pick_idx];
      id_q <= pick_idx;
    end
  end

endmodule
